conv_window_sched: RTL and testbench

- Sequences one convolution subkernel (KERNEL_WIDTH x KERNEL_HEIGHT parallel MAC, sticky done, accumulating result) across a full input feature map.
- For each output position it:
  - reads the input window from a pixel memory into the subkernel X bus;
  - clears the subkernel and holds its start until done;
  - hands the result downstream over a valid/ready port tagged with row/col.
- Sits between the feature-map buffer and the subkernel instance in the conv layer top.

---
 rtl/conv_pkg.sv | 30 +++
 rtl/conv_addr_gen.sv | 33 +++
 rtl/conv_window_sched.sv | 217 +++++++++++++++++++++
 tb/tb_conv_window_sched.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the convolution window scheduler: FSM state
// encodings and helpers that derive the window and output-map sizes.
package conv_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE       = 3'd0;
  localparam state_t ST_CLEAR      = 3'd1;
  localparam state_t ST_FETCH      = 3'd2;
  localparam state_t ST_FETCH_WAIT = 3'd3;
  localparam state_t ST_COMPUTE    = 3'd4;
  localparam state_t ST_OUTPUT     = 3'd5;
  localparam state_t ST_DONE       = 3'd6;

  // Number of taps in one window.
  function automatic int calc_n(input int kw, input int kh);
    return kw * kh;
  endfunction

  // Output-map width for a given image width, kernel width and stride.
  function automatic int calc_out_w(input int img_w, input int kw, input int stride);
    return (img_w - kw) / stride + 1;
  endfunction

  // Output-map height for a given image height, kernel height and stride.
  function automatic int calc_out_h(input int img_h, input int kh, input int stride);
    return (img_h - kh) / stride + 1;
  endfunction

endpackage

// File: rtl/conv_addr_gen.sv
// Window address generator: turns the window origin (row0/col0) and a
// row-major tap index into a row-major pixel address, and flags the
// final tap of the window.
module conv_addr_gen
  import conv_pkg::*;
#(
  parameter int KERNEL_WIDTH  = 4,
  parameter int KERNEL_HEIGHT = 3,
  parameter int IMG_WIDTH     = 16,
  parameter int ADDR_W        = 8,
  parameter int TAP_W         = 4
) (
  input  logic [15:0]       row0_i,
  input  logic [15:0]       col0_i,
  input  logic [TAP_W-1:0]  tap_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_o
);

  localparam int N = calc_n(KERNEL_WIDTH, KERNEL_HEIGHT);

  int tap_r;
  int tap_c;

  // Split the tap index into window row/column and form the pixel address.
  always_comb begin
    tap_r  = int'(tap_i) / KERNEL_WIDTH;
    tap_c  = int'(tap_i) % KERNEL_WIDTH;
    addr_o = ADDR_W'((int'(row0_i) + tap_r) * IMG_WIDTH + int'(col0_i) + tap_c);
    last_o = (int'(tap_i) == N - 1);
  end

endmodule

// File: rtl/conv_window_sched.sv
// Convolution window scheduler: walks every output position of the
// feature map, fetches the input window into the subkernel X bus, runs
// the subkernel to completion and hands the result downstream with its
// row/col tag.
// Optional build macro CONV_TIMEOUT_EN adds a compute watchdog that sets
// the sticky err output and abandons the frame if sk_done never arrives.
module conv_window_sched
  import conv_pkg::*;
#(
  parameter int IN_BIT_SIZE    = 8,
  parameter int OUT_BIT_SIZE   = 20,
  parameter int KERNEL_WIDTH   = 4,
  parameter int KERNEL_HEIGHT  = 3,
  parameter int IMG_WIDTH      = 16,
  parameter int IMG_HEIGHT     = 12,
  parameter int STRIDE         = 1,
  parameter int ADDR_W         = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          frame_start,
  output logic                                          busy,
  output logic                                          frame_done,
  output logic                                          mem_rd_en,
  output logic [ADDR_W-1:0]                             mem_addr,
  input  logic [IN_BIT_SIZE-1:0]                        mem_rd_data,
  output logic                                          sk_reset,
  output logic                                          sk_start,
  output logic [KERNEL_WIDTH*KERNEL_HEIGHT*IN_BIT_SIZE-1:0] sk_x,
  input  logic                                          sk_done,
  input  logic [OUT_BIT_SIZE-1:0]                       sk_result,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic [OUT_BIT_SIZE-1:0]                       out_data,
  output logic [15:0]                                   out_row,
  output logic [15:0]                                   out_col,
  output logic                                          err
);

  localparam int N     = calc_n(KERNEL_WIDTH, KERNEL_HEIGHT);
  localparam int OUT_W = calc_out_w(IMG_WIDTH, KERNEL_WIDTH, STRIDE);
  localparam int OUT_H = calc_out_h(IMG_HEIGHT, KERNEL_HEIGHT, STRIDE);
  localparam int TAP_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [15:0] LAST_COL = 16'(OUT_W - 1);
  localparam logic [15:0] LAST_ROW = 16'(OUT_H - 1);

  state_t                    state_q, state_d;
  logic [15:0]               row_q, row_d;
  logic [15:0]               col_q, col_d;
  logic [TAP_W-1:0]          tap_q, tap_d;
  logic                      out_valid_q, out_valid_d;
  logic [OUT_BIT_SIZE-1:0]   out_data_q, out_data_d;
  logic                      rd_vld_q;
  logic [TAP_W-1:0]          cap_idx_q;
  logic [N*IN_BIT_SIZE-1:0]  sk_x_q;
  logic [15:0]               row0;
  logic [15:0]               col0;
  logic [ADDR_W-1:0]         win_addr;
  logic                      last_tap;
  logic                      tmo_hit;

  assign row0 = 16'(int'(row_q) * STRIDE);
  assign col0 = 16'(int'(col_q) * STRIDE);

  conv_addr_gen #(
    .KERNEL_WIDTH  (KERNEL_WIDTH),
    .KERNEL_HEIGHT (KERNEL_HEIGHT),
    .IMG_WIDTH     (IMG_WIDTH),
    .ADDR_W        (ADDR_W),
    .TAP_W         (TAP_W)
  ) u_addr_gen (
    .row0_i (row0),
    .col0_i (col0),
    .tap_i  (tap_q),
    .addr_o (win_addr),
    .last_o (last_tap)
  );

  // Next-state logic: window sequencing, result capture and position advance.
  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    tap_d       = tap_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    case (state_q)
      ST_IDLE: begin
        if (frame_start) begin
          state_d = ST_CLEAR;
          row_d   = '0;
          col_d   = '0;
        end
      end
      ST_CLEAR: begin
        state_d = ST_FETCH;
        tap_d   = '0;
      end
      ST_FETCH: begin
        if (last_tap) begin
          state_d = ST_FETCH_WAIT;
          tap_d   = '0;
        end else begin
          tap_d = tap_q + 1'b1;
        end
      end
      ST_FETCH_WAIT: state_d = ST_COMPUTE;
      ST_COMPUTE: begin
        if (sk_done) begin
          out_data_d  = sk_result;
          out_valid_d = 1'b1;
          state_d     = ST_OUTPUT;
        end else if (tmo_hit) begin
          state_d = ST_IDLE;
        end
      end
      ST_OUTPUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (col_q == LAST_COL) begin
            col_d = '0;
            if (row_q == LAST_ROW) begin
              row_d   = '0;
              state_d = ST_DONE;
            end else begin
              row_d   = row_q + 16'd1;
              state_d = ST_CLEAR;
            end
          end else begin
            col_d   = col_q + 16'd1;
            state_d = ST_CLEAR;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM, position counters and output stage registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      row_q       <= '0;
      col_q       <= '0;
      tap_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      tap_q       <= tap_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // Read data lands one cycle after the strobe; remember which tap it belongs to.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_vld_q  <= 1'b0;
      cap_idx_q <= '0;
      sk_x_q    <= '0;
    end else begin
      rd_vld_q  <= mem_rd_en;
      cap_idx_q <= tap_q;
      if (rd_vld_q) begin
        for (int i = 0; i < N; i++) begin
          if (cap_idx_q == TAP_W'(i)) sk_x_q[i*IN_BIT_SIZE +: IN_BIT_SIZE] <= mem_rd_data;
        end
      end
    end
  end

`ifdef CONV_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_cnt_q;
  logic             err_q;

  assign tmo_hit = (state_q == ST_COMPUTE) && !sk_done &&
                   (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));

  // Watchdog: count cycles spent in COMPUTE; sticky error until the next frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      if (state_q == ST_COMPUTE) tmo_cnt_q <= tmo_cnt_q + 1'b1;
      else                       tmo_cnt_q <= '0;
      if (tmo_hit)                                  err_q <= 1'b1;
      else if (state_q == ST_IDLE && frame_start)   err_q <= 1'b0;
    end
  end

  assign err = err_q;
`else
  assign tmo_hit = 1'b0;
  assign err     = 1'b0;
`endif

  assign busy       = (state_q != ST_IDLE);
  assign frame_done = (state_q == ST_DONE);
  assign mem_rd_en  = (state_q == ST_FETCH);
  assign mem_addr   = mem_rd_en ? win_addr : '0;
  assign sk_reset   = (state_q != ST_COMPUTE);
  assign sk_start   = (state_q == ST_COMPUTE);
  assign sk_x       = sk_x_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_row    = row_q;
  assign out_col    = col_q;

endmodule

// File: tb/tb_conv_window_sched.sv
// Bench for conv_window_sched: pixel memory and a behavioural summing
// subkernel (all weights 1, done two cycles after start) around the DUT,
// with a result scoreboard checked by an independent monitor.
module tb_conv_window_sched;

  localparam int OW = 13;
  localparam int OH = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_start;
  logic        busy, frame_done, mem_rd_en;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_rd_data;
  logic        sk_reset, sk_start;
  logic [95:0] sk_x;
  logic        sk_done;
  logic [19:0] sk_result;
  logic        out_valid, out_ready;
  logic [19:0] out_data;
  logic [15:0] out_row, out_col;
  logic        err;

  typedef struct {
    int          row;
    int          col;
    logic [19:0] data;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0, fails = 0;
  int          hs_cnt = 0, done_cnt = 0, hold_n = 0;
  int          hs0, done0;
  int          mode = 0;
  bit          sk_hold = 0;
  int          sk_cnt;
  logic [19:0] first_data;
  bit          prev_stall = 0;
  logic [19:0] prev_data;
  logic [15:0] prev_row, prev_col;

  always #5 clk = ~clk;

  conv_window_sched dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .busy(busy),
    .frame_done(frame_done), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_rd_data(mem_rd_data), .sk_reset(sk_reset), .sk_start(sk_start),
    .sk_x(sk_x), .sk_done(sk_done), .sk_result(sk_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_col(out_col), .err(err)
  );

  function automatic int pix(input int m, input int a);
    if (m == 0) return 1;
    if (m == 1) return a % 128;
    return a - 100;
  endfunction

  function automatic logic [19:0] exp_val(input int m, input int row, input int col);
    int s = 0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 4; c++)
        s += pix(m, (row + r) * 16 + col + c);
    return 20'(s);
  endfunction

  function automatic int xsum(input logic [95:0] x);
    int s = 0;
    for (int i = 0; i < 12; i++) s += int'($signed(x[i*8 +: 8]));
    return s;
  endfunction

  // Pixel memory with one-cycle read latency.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= 8'(pix(mode, int'(mem_addr)));
  end

  // Behavioural subkernel: sticky done two cycles into start.
  always @(posedge clk) begin
    if (sk_reset) begin
      sk_done   <= 1'b0;
      sk_result <= '0;
      sk_cnt    <= 0;
    end else if (sk_start && !sk_hold) begin
      if (sk_cnt == 2) begin
        sk_done   <= 1'b1;
        sk_result <= 20'(xsum(sk_x));
      end else begin
        sk_cnt <= sk_cnt + 1;
      end
    end
  end

  // Monitor: handshake scoreboard, stall stability and frame_done counting.
  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        tests++;
        hold_n++;
        if (!(out_valid && out_data == prev_data && out_row == prev_row && out_col == prev_col)) begin
          fails++;
          $display("FAIL hold: got v=%0b d=%0h r=%0d c=%0d, required v=1 d=%0h r=%0d c=%0d",
                   out_valid, out_data, out_row, out_col, prev_data, prev_row, prev_col);
        end
      end
      if (out_valid && out_ready) begin
        exp_t e;
        hs_cnt++;
        if (out_row == 16'd0 && out_col == 16'd0) first_data = out_data;
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL result: got unexpected r=%0d c=%0d d=%0h, required no result",
                   out_row, out_col, out_data);
        end else begin
          e = sb.pop_front();
          if (out_data !== e.data || int'(out_row) != e.row || int'(out_col) != e.col) begin
            fails++;
            $display("FAIL result: got r=%0d c=%0d d=%0h, required r=%0d c=%0d d=%0h",
                     out_row, out_col, out_data, e.row, e.col, e.data);
          end
        end
      end
      if (frame_done) done_cnt++;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_row   = out_row;
      prev_col   = out_col;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input longint act, input longint req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  task automatic start_frame(input int m);
    mode = m;
    for (int r = 0; r < OH; r++)
      for (int c = 0; c < OW; c++)
        sb.push_back('{r, c, exp_val(m, r, c)});
    hs0 = hs_cnt;
    done0 = done_cnt;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic finish_frame(input string nm);
    int n = 0;
    while (done_cnt == done0 && n < 6000) begin
      tick();
      n++;
    end
    check({nm, "_finished"}, (done_cnt != done0), 1);
    repeat (3) tick();
    check({nm, "_results"}, hs_cnt - hs0, OW * OH);
    check({nm, "_done_pulses"}, done_cnt - done0, 1);
    check({nm, "_sb_empty"}, sb.size(), 0);
    check({nm, "_busy"}, busy, 0);
  endtask

  initial begin
    int  h, d, n;
    bit  found;
    reset = 1'b1;
    frame_start = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_sk_reset", sk_reset, 1);
    check("rst_sk_start", sk_start, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_rd_en", mem_rd_en, 0);
    check("rst_sk_x_zero", (sk_x == '0), 1);
    check("rst_row_col", {out_row, out_col}, 0);
    check("rst_err", err, 0);
    reset = 1'b0;
    tick();

    // All-ones frame: every window sums to 12.
    start_frame(0);
    finish_frame("ones");

    // Ramp frame: check the window layout of position (0,0) on the X bus.
    start_frame(1);
    n = 0;
    while (!sk_start && n < 100) begin tick(); n++; end
    check("first_compute_seen", sk_start, 1);
    for (int i = 0; i < 12; i++)
      check($sformatf("tap%0d", i), sk_x[i*8 +: 8], (i / 4) * 16 + i % 4);
    finish_frame("ramp");
    check("ramp_first_result", first_data, 210);

    // Back-pressure at (2,5) for 20 cycles on a signed frame.
    start_frame(2);
    found = 0; n = 0;
    while (!found && n < 3000) begin
      if (mem_rd_en && out_row == 16'd2 && out_col == 16'd5) found = 1;
      else begin tick(); n++; end
    end
    check("stall_pos_reached", found, 1);
    out_ready = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin tick(); n++; end
    check("stall_valid_seen", out_valid, 1);
    h = hold_n;
    repeat (20) tick();
    out_ready = 1'b1;
    tick();
    check("stall_hold_cycles", hold_n - h, 20);
    finish_frame("stall");

    // frame_start while busy is ignored.
    start_frame(2);
    repeat (300) tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    finish_frame("restart_ignored");

    // Reset during FETCH of (4,7) aborts the frame.
    start_frame(1);
    found = 0; n = 0;
    while (!found && n < 4000) begin
      if (mem_rd_en && out_row == 16'd4 && out_col == 16'd7) found = 1;
      else begin tick(); n++; end
    end
    check("abort_pos_reached", found, 1);
    reset = 1'b1;
    tick();
    check("abort_busy", busy, 0);
    check("abort_sk_reset", sk_reset, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_row_col", {out_row, out_col}, 0);
    reset = 1'b0;
    sb.delete();
    h = hs_cnt;
    d = done_cnt;
    repeat (10) tick();
    check("abort_no_result", hs_cnt - h, 0);
    check("abort_no_done", done_cnt - d, 0);
    first_data = '0;
    start_frame(1);
    finish_frame("after_abort");
    check("after_abort_first", first_data, 210);

`ifdef CONV_TIMEOUT_EN
    // Watchdog: subkernel never finishes.
    sk_hold = 1'b1;
    start_frame(0);
    h = hs_cnt;
    d = done_cnt;
    n = 0;
    while (!err && n < 300) begin tick(); n++; end
    check("tmo_err", err, 1);
    check("tmo_busy", busy, 0);
    check("tmo_no_result", hs_cnt - h, 0);
    check("tmo_no_done", done_cnt - d, 0);
    sb.delete();
    sk_hold = 1'b0;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("tmo_err_cleared", err, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
